// File: rtl/secuenciador_fetch_pkg.sv
// Shared definitions for the fetch/issue controller: opcodes, FSM states,
// the bubble word and the branch-target helper.
package secuenciador_fetch_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // All-zero word decodes as an R-type writing $0, so it is a safe bubble.
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic {
        FETCH   = 1'b0,
        BR_WAIT = 1'b1
    } state_t;

    // Branch target relative to the sequential PC; wraps modulo 2^32.
    function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                   input logic [15:0] imm16);
        return pc4 + {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/secuenciador_fetch_marcador.sv
// Pending-write scoreboard: a WB_LAT-deep shift line of {valid, wa} that
// reports whether either source register is still waiting for write-back.
module marcador_escritura
    import secuenciador_fetch_pkg::*;
#(
    parameter int WB_LAT = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_vld_i,
    input  logic [4:0] push_wa_i,
    input  logic [4:0] rs_i,
    input  logic       rs_use_i,
    input  logic [4:0] rt_i,
    input  logic       rt_use_i,
    output logic       hit_o
);

    logic [WB_LAT-1:0]      vld_q;
    logic [WB_LAT-1:0][4:0] wa_q;

    // Shift every clock; entry 0 is the write issued on the last edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            wa_q  <= '0;
        end else begin
            vld_q[0] <= push_vld_i && (push_wa_i != 5'd0);
            wa_q[0]  <= push_wa_i;
            for (int i = 1; i < WB_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                wa_q[i]  <= wa_q[i-1];
            end
        end
    end

    // Match any live entry against the non-zero sources in use.
    always_comb begin
        hit_o = 1'b0;
        for (int i = 0; i < WB_LAT; i++) begin
            if (vld_q[i]) begin
                if (rs_use_i && (rs_i != 5'd0) && (rs_i == wa_q[i])) hit_o = 1'b1;
                if (rt_use_i && (rt_i != 5'd0) && (rt_i == wa_q[i])) hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/secuenciador_fetch.sv
// Fetch/issue controller: owns the PC, issues instructions or bubbles,
// stalls on RAW hazards against delayed write-back, resolves BEQ one cycle
// after issue and redirects on J.
module secuenciador_fetch
    import secuenciador_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          WB_LAT   = 2
) (
    input  logic        clk_sf,
    input  logic        rst_sf,
    input  logic        en_sf,
    input  logic [31:0] imem_data_sf,
    input  logic        zero_sf,
    output logic [31:0] pc_sf,
    output logic [31:0] instr_sf,
    output logic        issue_sf,
    output logic        stall_sf,
    output logic        flush_sf
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, seq_q;
    logic        br_capture;

    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic        rs_use, rt_use;
    logic        dst_vld;
    logic [4:0]  dst_wa;
    logic        push_vld;
    logic        hazard;
    logic        run;
    logic [31:0] pc4;

    assign op     = imem_data_sf[31:26];
    assign rs     = imem_data_sf[25:21];
    assign rt     = imem_data_sf[20:16];
    assign rd     = imem_data_sf[15:11];
    assign pc4    = pc_q + 32'd4;
    assign pc_sf  = pc_q;
    // Nothing issues while reset is held, even before the edge clears state.
    assign run    = en_sf && !rst_sf;
    assign rs_use = (op != OP_J);
    assign rt_use = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);

    // Destination decode; $0 is dropped by the scoreboard.
    always_comb begin
        dst_vld = 1'b0;
        dst_wa  = 5'd0;
        case (op)
            OP_RTYPE: begin
                dst_vld = 1'b1;
                dst_wa  = rd;
            end
            OP_LW, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
                dst_vld = 1'b1;
                dst_wa  = rt;
            end
            default: ;
        endcase
    end

    marcador_escritura #(
        .WB_LAT(WB_LAT)
    ) u_marcador (
        .clk_i      (clk_sf),
        .rst_i      (rst_sf),
        .push_vld_i (push_vld),
        .push_wa_i  (dst_wa),
        .rs_i       (rs),
        .rs_use_i   (rs_use),
        .rt_i       (rt),
        .rt_use_i   (rt_use),
        .hit_o      (hazard)
    );

    // Next-state, next-PC and issue outputs.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_sf   = NOP_WORD;
        issue_sf   = 1'b0;
        stall_sf   = 1'b0;
        flush_sf   = 1'b0;
        push_vld   = 1'b0;
        br_capture = 1'b0;
        case (state_q)
            FETCH: begin
                if (run) begin
                    if (hazard) begin
                        stall_sf = 1'b1;
                    end else begin
                        issue_sf = 1'b1;
                        instr_sf = imem_data_sf;
                        push_vld = dst_vld;
                        case (op)
                            OP_J:    pc_d = {pc4[31:28], imem_data_sf[25:0], 2'b00};
                            OP_BEQ: begin
                                state_d    = BR_WAIT;
                                br_capture = 1'b1;
                            end
                            default: pc_d = pc4;
                        endcase
                    end
                end
            end
            BR_WAIT: begin
                // Resolves regardless of en_sf so a branch is never left half-done.
                flush_sf = 1'b1;
                pc_d     = zero_sf ? tgt_q : seq_q;
                state_d  = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Control state and PC.
    always_ff @(posedge clk_sf or posedge rst_sf) begin
        if (rst_sf) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Branch candidates captured when a BEQ issues; only read in BR_WAIT.
    always_ff @(posedge clk_sf) begin
        if (br_capture) begin
            tgt_q <= branch_target(pc4, imem_data_sf[15:0]);
            seq_q <= pc4;
        end
    end

endmodule

// File: tb/tb_secuenciador_fetch.sv
// Self-checking bench for secuenciador_fetch: directed scenarios plus a
// randomized run against a cycle-level reference model.
module tb_secuenciador_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          WBL    = 2;

    logic        clk_sf = 1'b0;
    logic        rst_sf = 1'b1;
    logic        en_sf  = 1'b0;
    logic [31:0] imem_data_sf = 32'h0;
    logic        zero_sf = 1'b0;
    logic [31:0] pc_sf, instr_sf;
    logic        issue_sf, stall_sf, flush_sf;

    int total = 0;
    int bad   = 0;

    secuenciador_fetch #(.RESET_PC(RST_PC), .WB_LAT(WBL)) dut (
        .clk_sf       (clk_sf),
        .rst_sf       (rst_sf),
        .en_sf        (en_sf),
        .imem_data_sf (imem_data_sf),
        .zero_sf      (zero_sf),
        .pc_sf        (pc_sf),
        .instr_sf     (instr_sf),
        .issue_sf     (issue_sf),
        .stall_sf     (stall_sf),
        .flush_sf     (flush_sf)
    );

    always #5 clk_sf = ~clk_sf;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk_r(input int s, input int t, input int d);
        return {6'h00, 5'(s), 5'(t), 5'(d), 11'h020};
    endfunction
    function automatic logic [31:0] mk_i(input logic [5:0] op, input int s, input int t,
                                         input logic [15:0] imm);
        return {op, 5'(s), 5'(t), imm};
    endfunction
    function automatic logic [31:0] mk_j(input logic [25:0] imm26);
        return {6'h02, imm26};
    endfunction

    // Present one cycle of inputs after the falling edge and let them settle.
    task automatic drive(input logic e, input logic [31:0] w, input logic z);
        @(negedge clk_sf);
        en_sf = e;
        imem_data_sf = w;
        zero_sf = z;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_sf);
        rst_sf = 1'b1;
        en_sf = 1'b0;
        imem_data_sf = 32'h0;
        zero_sf = 1'b0;
        @(negedge clk_sf);
        rst_sf = 1'b0;
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_pc, m_tgt, m_seq;
    bit          m_br;
    int          m_busy [32];
    int          m_cyc;
    logic [31:0] x_instr;
    bit          x_issue, x_stall, x_flush;

    task automatic model_reset();
        m_pc = RST_PC;
        m_br = 0;
        m_cyc = 0;
        for (int r = 0; r < 32; r++) m_busy[r] = -1000;
    endtask

    task automatic model_eval(input logic e, input logic [31:0] w);
        logic [5:0] op;
        int rs, rt;
        bit hz;
        op = w[31:26];
        rs = int'(w[25:21]);
        rt = int'(w[20:16]);
        hz = 0;
        if (op != 6'h02 && rs != 0 && m_busy[rs] >= m_cyc) hz = 1;
        if ((op == 6'h00 || op == 6'h04 || op == 6'h2B) && rt != 0 && m_busy[rt] >= m_cyc) hz = 1;
        x_instr = 32'h0; x_issue = 0; x_stall = 0; x_flush = 0;
        if (m_br) x_flush = 1;
        else if (!e) ;
        else if (hz) x_stall = 1;
        else begin
            x_issue = 1;
            x_instr = w;
        end
    endtask

    task automatic model_update(input logic [31:0] w, input logic z);
        logic [5:0]  op;
        logic [31:0] p4;
        int dst;
        op = w[31:26];
        p4 = m_pc + 32'd4;
        if (m_br) begin
            m_pc = z ? m_tgt : m_seq;
            m_br = 0;
        end else if (x_issue) begin
            dst = 0;
            if (op == 6'h00) dst = int'(w[15:11]);
            if (op == 6'h23 || op == 6'h08 || op == 6'h0C || op == 6'h0D || op == 6'h0A)
                dst = int'(w[20:16]);
            if (dst != 0) m_busy[dst] = m_cyc + WBL;
            if (op == 6'h02) m_pc = {p4[31:28], w[25:0], 2'b00};
            else if (op == 6'h04) begin
                m_tgt = p4 + 32'(signed'(w[15:0])) * 4;
                m_seq = p4;
                m_br  = 1;
            end else m_pc = p4;
        end
        m_cyc++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        total++; if (pc_sf !== RST_PC) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc_sf, RST_PC); end
        total++; if (issue_sf !== 1'b0 || stall_sf !== 1'b0 || flush_sf !== 1'b0 || instr_sf !== 32'h0) begin
            bad++; $display("FAIL reset_flags got=%b%b%b/%h exp=000/0", issue_sf, stall_sf, flush_sf, instr_sf);
        end
        drive(1, mk_r(0, 0, 1), 0);
        drive(1, mk_r(0, 0, 2), 0);
        drive(1, mk_r(0, 0, 4), 0);
        rst_sf = 1'b1;
        #1;
        total++; if (pc_sf !== RST_PC || issue_sf !== 1'b0 || instr_sf !== 32'h0) begin
            bad++; $display("FAIL async_reset got pc=%h issue=%b instr=%h exp pc=%h issue=0 instr=0",
                            pc_sf, issue_sf, instr_sf, RST_PC);
        end
        @(negedge clk_sf);
        rst_sf = 1'b0;
    endtask

    task automatic test_raw_stall();
        logic [31:0] w2;
        w2 = mk_r(3, 4, 5);
        do_reset();
        drive(1, mk_r(1, 2, 3), 0);
        total++; if (pc_sf !== 32'h0 || issue_sf !== 1'b1) begin bad++; $display("FAIL raw_first got pc=%h issue=%b exp 0/1", pc_sf, issue_sf); end
        for (int k = 0; k < 2; k++) begin
            drive(1, w2, 0);
            total++; if (pc_sf !== 32'h4 || stall_sf !== 1'b1 || issue_sf !== 1'b0 || instr_sf !== 32'h0) begin
                bad++; $display("FAIL raw_stall%0d got pc=%h stall=%b issue=%b instr=%h exp 4/1/0/0", k, pc_sf, stall_sf, issue_sf, instr_sf);
            end
        end
        drive(1, w2, 0);
        total++; if (pc_sf !== 32'h4 || stall_sf !== 1'b0 || issue_sf !== 1'b1 || instr_sf !== w2) begin
            bad++; $display("FAIL raw_issue got pc=%h stall=%b issue=%b instr=%h exp 4/0/1/%h", pc_sf, stall_sf, issue_sf, instr_sf, w2);
        end
        drive(0, 32'h0, 0);
        total++; if (pc_sf !== 32'h8) begin bad++; $display("FAIL raw_pc_after got=%h exp=8", pc_sf); end
    endtask

    task automatic test_independent();
        logic [31:0] ws [3];
        ws[0] = mk_r(2, 3, 1);
        ws[1] = mk_r(5, 6, 4);
        ws[2] = mk_r(2, 5, 7);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, ws[i], 0);
            total++; if (pc_sf !== 32'(4 * i) || issue_sf !== 1'b1 || stall_sf !== 1'b0) begin
                bad++; $display("FAIL indep%0d got pc=%h issue=%b stall=%b exp %h/1/0", i, pc_sf, issue_sf, stall_sf, 32'(4 * i));
            end
        end
        drive(0, 32'h0, 0);
        total++; if (pc_sf !== 32'hC || issue_sf !== 1'b0) begin bad++; $display("FAIL indep_end got pc=%h issue=%b exp c/0", pc_sf, issue_sf); end
    endtask

    task automatic test_beq();
        logic [15:0] imm [3];
        logic        zz  [3];
        logic        een [3];
        logic [31:0] exp [3];
        imm[0] = 16'd3;    zz[0] = 1; een[0] = 1; exp[0] = 32'h20;
        imm[1] = 16'd3;    zz[1] = 0; een[1] = 0; exp[1] = 32'h14;
        imm[2] = 16'hFFFF; zz[2] = 1; een[2] = 1; exp[2] = 32'h10;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, mk_j(26'h4), 0);
            drive(1, mk_i(6'h04, 0, 0, imm[k]), 0);
            total++; if (pc_sf !== 32'h10 || issue_sf !== 1'b1) begin
                bad++; $display("FAIL beq%0d_issue got pc=%h issue=%b exp 10/1", k, pc_sf, issue_sf);
            end
            drive(een[k], mk_r(1, 2, 3), zz[k]);
            total++; if (flush_sf !== 1'b1 || issue_sf !== 1'b0 || instr_sf !== 32'h0 || pc_sf !== 32'h10) begin
                bad++; $display("FAIL beq%0d_flush got flush=%b issue=%b instr=%h pc=%h exp 1/0/0/10", k, flush_sf, issue_sf, instr_sf, pc_sf);
            end
            drive(0, 32'h0, 0);
            total++; if (pc_sf !== exp[k] || flush_sf !== 1'b0) begin
                bad++; $display("FAIL beq%0d_target got pc=%h flush=%b exp %h/0", k, pc_sf, flush_sf, exp[k]);
            end
        end
    endtask

    task automatic test_jump();
        do_reset();
        drive(1, mk_j(26'h3FF_FFFF), 0);
        total++; if (issue_sf !== 1'b1) begin bad++; $display("FAIL jump_issue got=%b exp=1", issue_sf); end
        drive(1, mk_j(26'h40), 0);
        total++; if (pc_sf !== 32'h0FFF_FFFC || issue_sf !== 1'b1 || flush_sf !== 1'b0) begin
            bad++; $display("FAIL jump_chain got pc=%h issue=%b flush=%b exp 0ffffffc/1/0", pc_sf, issue_sf, flush_sf);
        end
        drive(0, 32'h0, 0);
        total++; if (pc_sf !== 32'h1000_0100) begin bad++; $display("FAIL jump_region got=%h exp=10000100", pc_sf); end
    endtask

    task automatic test_reset_in_branch();
        logic [31:0] dep;
        dep = mk_r(3, 4, 5);
        do_reset();
        drive(1, mk_r(1, 2, 3), 0);
        drive(1, mk_i(6'h04, 0, 0, 16'd5), 0);
        drive(1, 32'h0, 1);
        total++; if (flush_sf !== 1'b1) begin bad++; $display("FAIL rstbr_flush got=%b exp=1", flush_sf); end
        rst_sf = 1'b1;
        #1;
        total++; if (pc_sf !== RST_PC || flush_sf !== 1'b0) begin
            bad++; $display("FAIL rstbr_reset got pc=%h flush=%b exp %h/0", pc_sf, flush_sf, RST_PC);
        end
        rst_sf = 1'b0;
        imem_data_sf = dep;
        #1;
        total++; if (issue_sf !== 1'b1 || stall_sf !== 1'b0 || pc_sf !== RST_PC) begin
            bad++; $display("FAIL rstbr_sb_clear got issue=%b stall=%b pc=%h exp 1/0/%h", issue_sf, stall_sf, pc_sf, RST_PC);
        end
        drive(0, 32'h0, 0);
        total++; if (pc_sf !== RST_PC + 32'd4) begin bad++; $display("FAIL rstbr_next got=%h exp=%h", pc_sf, RST_PC + 32'd4); end
    endtask

    task automatic test_random();
        logic [5:0]  op_tab [10];
        logic [31:0] w;
        logic        e, z;
        op_tab = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h3F};
        do_reset();
        model_reset();
        for (int c = 0; c < 800; c++) begin
            e = ($urandom_range(9) != 0);
            z = 1'($urandom_range(1));
            w = {op_tab[$urandom_range(9)], 5'($urandom_range(7)), 5'($urandom_range(7)),
                 5'($urandom_range(7)), 11'($urandom)};
            drive(e, w, z);
            model_eval(e, w);
            total++; if (pc_sf !== m_pc) begin bad++; $display("FAIL rnd_pc c=%0d got=%h exp=%h", c, pc_sf, m_pc); end
            total++; if (issue_sf !== x_issue || instr_sf !== x_instr) begin
                bad++; $display("FAIL rnd_issue c=%0d got=%b/%h exp=%b/%h", c, issue_sf, instr_sf, x_issue, x_instr);
            end
            total++; if (stall_sf !== x_stall) begin bad++; $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, stall_sf, x_stall); end
            total++; if (flush_sf !== x_flush) begin bad++; $display("FAIL rnd_flush c=%0d got=%b exp=%b", c, flush_sf, x_flush); end
            model_update(w, z);
        end
    endtask

    initial begin
        test_reset();
        test_raw_stall();
        test_independent();
        test_beq();
        test_jump();
        test_reset_in_branch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
